pu_violation_log: RTL and testbench
===================================

// Module: pu_violation_log
// PURPOSE
// - Downstream consumer of the ProtectionUnit violation event stream.
// - Buffers denied AXI accesses (addr, AXI ID, R/W, matching policy rule) in a FWFT FIFO.
// - Raises a sticky interrupt and exposes the log head to the config register block for software pop.
// - Never backpressures the ProtectionUnit: when the FIFO is full, events are dropped and counted.
// PARAMETERS
// ADDR_W      32  width of the logged AXI address
// ID_W        4   width of the logged AXI ID
// RULE_W      4   width of the policy-rule index
// DEPTH       16  FIFO entries; power of two, >=2
// IRQ_THRESH  1   occupancy (1..DEPTH) at which irq asserts
// PORTS
// aclk        in   1                   clock; all logic on rising edge
// areset      in   1                   asynchronous, active-high reset
// log_en      in   1                   1 = capture events; 0 = events ignored (neither logged nor counted as dropped)
// viol_valid  in   1                   single-cycle violation event from ProtectionUnit
// viol_ready  out  1                   constant 1 (no backpressure)
// viol_addr   in   ADDR_W              denied address
// viol_id     in   ID_W                AXI ID of the denied transaction
// viol_write  in   1                   1 = write channel, 0 = read channel
// viol_rule   in   RULE_W              policy rule index that denied the access
// log_valid   out  1                   FIFO non-empty; log_* fields show the head entry
// log_addr    out  ADDR_W              head address
// log_id      out  ID_W                head ID
// log_write   out  1                   head R/W flag
// log_rule    out  RULE_W              head rule index
// log_ts      out  32                  head timestamp (see CONFIGURATION)
// log_pop     in   1                   pulse: discard head entry
// log_count   out  $clog2(DEPTH)+1     current occupancy
// drop_cnt    out  16                  saturating count of dropped events
// irq         out  1                   sticky interrupt
// irq_clear   in   1                   pulse: clear irq and drop_cnt
// BEHAVIOUR
// - Reset: FIFO empty; log_valid=0; log_count=0; drop_cnt=0; irq=0. log_* data outputs =0.
//   Timestamp counter =0. viol_ready=1 at all times, including during reset.
// - Push: a cycle with viol_valid & log_en writes the entry at the tail.
//   The entry appears at the head (log_valid=1) one cycle later if the FIFO was empty.
// - Pop: log_pop with log_valid=1 advances the head. The next entry, or log_valid=0, is visible the next cycle.
//   log_pop with the FIFO empty is ignored; no underflow occurs.
// - Simultaneous push and pop:
//   - Both take effect and log_count is unchanged.
//   - When the FIFO is full, the pop frees a slot and the push is accepted (no drop).
//   - When the FIFO is empty, only the push takes effect; the pop is ignored.
// - Full with no pop: the incoming event is dropped, FIFO contents are unchanged,
//   and drop_cnt increments, saturating at 16'hFFFF.
// - Pointers: $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. full = MSBs differ and low bits are equal.
// - irq: set on the cycle after (log_count >= IRQ_THRESH) or a drop occurs; stays set until irq_clear.
//   - irq_clear clears irq and drop_cnt on the next edge.
//   - If a set condition is present in the same cycle as irq_clear, set wins: irq stays 1.
//     drop_cnt is cleared, then increments if that cycle also drops an event.
// - log_en falling mid-operation: stored entries are retained and remain poppable.
// - areset asserted at any time: the FIFO is flushed immediately (asynchronous); no partial entry survives.
// CONFIGURATION
// - PU_LOG_TIMESTAMP_EN defined:
//   - A free-running 32-bit cycle counter (wraps 0xFFFFFFFF->0) is stored with each entry.
//   - log_ts shows the head entry's counter value captured in its push cycle.
// - PU_LOG_TIMESTAMP_EN undefined: no counter and no timestamp storage; log_ts is tied to 32'h0.
// TESTING
// - Single event addr=0x4000_0010, id=3, write=1, rule=2:
//   log_valid=1 next cycle with matching fields; log_count=1; irq=1 one cycle later (IRQ_THRESH=1).
// - 16 back-to-back events, then 2 more:
//   log_count=16, drop_cnt=2; popping 16 times returns entries 0..15 in order; log_valid=0 afterwards.
// - FIFO full, push+pop in the same cycle: no drop; log_count stays 16; the head advances by one entry.
// - irq_clear with an empty FIFO: irq=0 and drop_cnt=0. irq_clear while count>=IRQ_THRESH: irq stays 1.
// - 5 events then areset mid-stream: log_valid, log_count and irq read 0 immediately; pop after reset is ignored.
// - With PU_LOG_TIMESTAMP_EN: events 10 cycles apart yield log_ts values differing by exactly 10;
//   without the macro, log_ts=0.

Source files
------------

// File: rtl/pu_violation_log.sv
// ---------------------------------------------------------------------------
// pu_violation_log
//   Captures denied AXI accesses reported by the ProtectionUnit into a
//   first-word-fall-through FIFO. Software reads the head entry through the
//   log_* outputs and discards it with log_pop. The event stream is never
//   back-pressured: events that arrive while the FIFO is full are dropped and
//   counted in a saturating counter. A sticky interrupt flags pending entries
//   or drops.
//
//   Optional feature macro: PU_LOG_TIMESTAMP_EN
//     defined   - a free-running 32-bit cycle counter is stored with each
//                 entry and shown on log_ts for the head entry.
//     undefined - no counter, no timestamp storage; log_ts is tied to 0.
//
// Ports
//   aclk, areset          clock (rising edge), asynchronous active-high reset
//   log_en                1 = capture events, 0 = ignore them entirely
//   viol_valid/ready      single-cycle event strobe; ready is constant 1
//   viol_addr/id/write/rule  fields of the denied access
//   log_valid             FIFO non-empty; log_* show the head entry
//   log_addr/id/write/rule/ts  head entry fields (0 when empty)
//   log_pop               pulse: discard the head entry (ignored when empty)
//   log_count             current occupancy
//   drop_cnt              saturating count of dropped events
//   irq, irq_clear        sticky interrupt and its clear pulse
// ---------------------------------------------------------------------------
module pu_violation_log #(
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int RULE_W     = 4,
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     log_en,
    input  logic                     viol_valid,
    output logic                     viol_ready,
    input  logic [ADDR_W-1:0]        viol_addr,
    input  logic [ID_W-1:0]          viol_id,
    input  logic                     viol_write,
    input  logic [RULE_W-1:0]        viol_rule,
    output logic                     log_valid,
    output logic [ADDR_W-1:0]        log_addr,
    output logic [ID_W-1:0]          log_id,
    output logic                     log_write,
    output logic [RULE_W-1:0]        log_rule,
    output logic [31:0]              log_ts,
    input  logic                     log_pop,
    output logic [$clog2(DEPTH):0]   log_count,
    output logic [15:0]              drop_cnt,
    output logic                     irq,
    input  logic                     irq_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] THRESH = (AW+1)'(IRQ_THRESH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic              write;
        logic [RULE_W-1:0] rule;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        event_in;
    logic        pop_ok;
    logic        push_ok;
    logic        drop;
    logic        irq_set;

    assign viol_ready = 1'b1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign event_in = viol_valid & log_en;
    assign pop_ok   = log_pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_ok  = event_in & (~full | pop_ok);
    assign drop     = event_in & full & ~pop_ok;
    assign irq_set  = (count >= THRESH) | drop;

    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; flushing the pointers empties the
    // FIFO, and the output gating below hides stale contents.
    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= '{addr: viol_addr, id: viol_id,
                                               write: viol_write, rule: viol_rule};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            irq      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // A set condition wins over a simultaneous clear.
            if (irq_set)        irq <= 1'b1;
            else if (irq_clear) irq <= 1'b0;

            // Clear first, then count a drop that happens in the same cycle.
            if (irq_clear)                        drop_cnt <= {15'd0, drop};
            else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign log_valid = ~empty;
    assign log_count = count;
    assign log_addr  = empty ? '0 : head.addr;
    assign log_id    = empty ? '0 : head.id;
    assign log_write = empty ? 1'b0 : head.write;
    assign log_rule  = empty ? '0 : head.rule;

`ifdef PU_LOG_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (push_ok) ts_mem[wr_ptr[AW-1:0]] <= ts_cnt;
    end

    assign log_ts = empty ? '0 : ts_mem[rd_ptr[AW-1:0]];
`else
    assign log_ts = 32'h0;
`endif

endmodule

// File: tb/tb_pu_violation_log.sv
module tb_pu_violation_log;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        log_en;
    logic        viol_valid;
    logic        viol_ready;
    logic [31:0] viol_addr;
    logic [3:0]  viol_id;
    logic        viol_write;
    logic [3:0]  viol_rule;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [3:0]  log_id;
    logic        log_write;
    logic [3:0]  log_rule;
    logic [31:0] log_ts;
    logic        log_pop;
    logic [4:0]  log_count;
    logic [15:0] drop_cnt;
    logic        irq;
    logic        irq_clear;

    int checks = 0;
    int failures = 0;

    pu_violation_log dut (
        .aclk(aclk), .areset(areset), .log_en(log_en),
        .viol_valid(viol_valid), .viol_ready(viol_ready),
        .viol_addr(viol_addr), .viol_id(viol_id), .viol_write(viol_write),
        .viol_rule(viol_rule),
        .log_valid(log_valid), .log_addr(log_addr), .log_id(log_id),
        .log_write(log_write), .log_rule(log_rule), .log_ts(log_ts),
        .log_pop(log_pop), .log_count(log_count), .drop_cnt(drop_cnt),
        .irq(irq), .irq_clear(irq_clear)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  id;
        logic        wr;
        logic [3:0]  rule;
        logic        pop;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [3:0]  e_id;
        logic        e_wr;
        logic [3:0]  e_rule;
        logic [4:0]  e_count;
        logic        e_irq;
    } vec_t;

    localparam logic [31:0] A_ADDR = 32'h4000_0010;
    localparam logic [31:0] B_ADDR = 32'h1000_0004;
    localparam logic [31:0] C_ADDR = 32'h2000_0008;
    localparam logic [31:0] D_ADDR = 32'h3000_000C;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] id,
                         input logic w, input logic [3:0] r, input logic p, input logic c);
        viol_valid = v; viol_addr = a; viol_id = id; viol_write = w; viol_rule = r;
        log_pop = p; irq_clear = c;
        tick();
        viol_valid = 1'b0; log_pop = 1'b0; irq_clear = 1'b0;
    endtask

    function automatic logic [31:0] f_addr(int i);
        return 32'hA000_0000 + 32'(i) * 32'd4;
    endfunction

    task automatic check_head(input string tag, input logic [31:0] a, input logic [3:0] id,
                              input logic w, input logic [3:0] r);
        check({tag, " valid"}, {31'd0, log_valid}, 32'd1);
        check({tag, " addr"},  log_addr, a);
        check({tag, " id"},    {28'd0, log_id}, {28'd0, id});
        check({tag, " write"}, {31'd0, log_write}, {31'd0, w});
        check({tag, " rule"},  {28'd0, log_rule}, {28'd0, r});
    endtask

    initial begin
        logic [31:0] ts0;

        log_en = 1'b1; viol_valid = 1'b0; viol_addr = '0; viol_id = '0;
        viol_write = 1'b0; viol_rule = '0; log_pop = 1'b0; irq_clear = 1'b0;

        // ---------------- reset state ----------------
        #2 areset = 1'b1;
        #1;
        check("rst valid", {31'd0, log_valid}, 32'd0);
        check("rst count", {27'd0, log_count}, 32'd0);
        check("rst drop",  {16'd0, drop_cnt}, 32'd0);
        check("rst irq",   {31'd0, irq}, 32'd0);
        check("rst addr",  log_addr, 32'd0);
        check("rst ts",    log_ts, 32'd0);
        check("rst ready", {31'd0, viol_ready}, 32'd1);
        #20 areset = 1'b0;
        tick();

        // ---------------- table-driven vectors ----------------
        //            v  addr     id    w     rule  pop   clr   e_v   e_addr  e_id  e_w   e_rule e_cnt e_irq
        vecs[0] = '{1'b1, A_ADDR, 4'd3, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, A_ADDR, 4'd3, 1'b1, 4'd2, 5'd1, 1'b0};
        vecs[1] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, A_ADDR, 4'd3, 1'b1, 4'd2, 5'd1, 1'b1};
        vecs[2] = '{1'b1, B_ADDR, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, A_ADDR, 4'd3, 1'b1, 4'd2, 5'd2, 1'b1};
        vecs[3] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, B_ADDR, 4'd5, 1'b0, 4'd7, 5'd1, 1'b1};
        vecs[4] = '{1'b1, C_ADDR, 4'd9, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, C_ADDR, 4'd9, 1'b1, 4'hF, 5'd1, 1'b1};
        vecs[5] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 5'd0, 1'b1};
        vecs[6] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 5'd0, 1'b0};
        vecs[7] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 5'd0, 1'b0};
        vecs[8] = '{1'b1, D_ADDR, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, D_ADDR, 4'd0, 1'b0, 4'd1, 5'd1, 1'b0};
        vecs[9] = '{1'b0, 32'd0,  4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, D_ADDR, 4'd0, 1'b0, 4'd1, 5'd1, 1'b1};

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].id, vecs[i].wr, vecs[i].rule,
                  vecs[i].pop, vecs[i].clr);
            check($sformatf("vec%0d valid", i), {31'd0, log_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d addr", i),  log_addr, vecs[i].e_addr);
            check($sformatf("vec%0d id", i),    {28'd0, log_id}, {28'd0, vecs[i].e_id});
            check($sformatf("vec%0d write", i), {31'd0, log_write}, {31'd0, vecs[i].e_wr});
            check($sformatf("vec%0d rule", i),  {28'd0, log_rule}, {28'd0, vecs[i].e_rule});
            check($sformatf("vec%0d count", i), {27'd0, log_count}, {27'd0, vecs[i].e_count});
            check($sformatf("vec%0d irq", i),   {31'd0, irq}, {31'd0, vecs[i].e_irq});
            check($sformatf("vec%0d drop", i),  {16'd0, drop_cnt}, 32'd0);
        end

        // ---------------- fill, overflow, full push+pop, drain ----------------
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("pre-fill empty", {31'd0, log_valid}, 32'd0);
        for (int i = 0; i < 16; i++)
            drive(1'b1, f_addr(i), 4'(i), i[0], ~4'(i), 1'b0, 1'b0);
        check("fill count", {27'd0, log_count}, 32'd16);
        check("fill drop",  {16'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 32'hDEAD_0000, 4'hD, 1'b1, 4'hD, 1'b0, 1'b0);
        check("ovf count", {27'd0, log_count}, 32'd16);
        check("ovf drop",  {16'd0, drop_cnt}, 32'd2);
        check("ovf irq",   {31'd0, irq}, 32'd1);
        check_head("ovf head", f_addr(0), 4'd0, 1'b0, 4'hF);

        log_en = 1'b0;
        drive(1'b1, 32'hDEAD_0001, 4'hD, 1'b1, 4'hD, 1'b0, 1'b0);
        log_en = 1'b1;
        check("dis drop",  {16'd0, drop_cnt}, 32'd2);
        check("dis count", {27'd0, log_count}, 32'd16);

        drive(1'b1, 32'hDEAD_0002, 4'hD, 1'b1, 4'hD, 1'b0, 1'b1);
        check("clr+drop drop", {16'd0, drop_cnt}, 32'd1);
        check("clr+drop irq",  {31'd0, irq}, 32'd1);

        drive(1'b1, 32'h0000_0100, 4'hE, 1'b1, 4'h9, 1'b1, 1'b0);
        check("full pp drop",  {16'd0, drop_cnt}, 32'd1);
        check("full pp count", {27'd0, log_count}, 32'd16);

        for (int k = 1; k < 16; k++) begin
            check_head($sformatf("drain%0d", k), f_addr(k), 4'(k), k[0], ~4'(k));
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_head("drain last", 32'h0000_0100, 4'hE, 1'b1, 4'h9);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("drained valid", {31'd0, log_valid}, 32'd0);
        check("drained count", {27'd0, log_count}, 32'd0);

        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("clr empty irq",  {31'd0, irq}, 32'd0);
        check("clr empty drop", {16'd0, drop_cnt}, 32'd0);

        // ---------------- timestamps ----------------
        drive(1'b1, 32'h5000_0000, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0);
        ts0 = log_ts;
        for (int i = 0; i < 9; i++) tick();
        drive(1'b1, 32'h5000_0004, 4'd2, 1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        check_head("ts second", 32'h5000_0004, 4'd2, 1'b1, 4'd2);
`ifdef PU_LOG_TIMESTAMP_EN
        check("ts delta", log_ts - ts0, 32'd10);
`else
        check("ts first zero",  ts0, 32'd0);
        check("ts second zero", log_ts, 32'd0);
`endif
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 5; i++)
            drive(1'b1, 32'h6000_0000 + 32'(i), 4'(i), 1'b0, 4'(i), 1'b0, 1'b0);
        check("pre-rst count", {27'd0, log_count}, 32'd5);
        #2 areset = 1'b1;
        #1;
        check("arst valid", {31'd0, log_valid}, 32'd0);
        check("arst count", {27'd0, log_count}, 32'd0);
        check("arst irq",   {31'd0, irq}, 32'd0);
        check("arst addr",  log_addr, 32'd0);
        check("arst ready", {31'd0, viol_ready}, 32'd1);
        #3 areset = 1'b0;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("post-rst pop valid", {31'd0, log_valid}, 32'd0);
        check("post-rst pop count", {27'd0, log_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
